// File: rtl/delay_line_pr.sv
// delay_line_pr: DEPTH-stage WIDTH-bit register chain with per-stage valid, CE, flush,
// occupancy count and a selectable tap. The tap mux exists only when DELAY_LINE_PR_TAP_EN is defined.
module delay_line_pr #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2,
   parameter logic [WIDTH-1:0] INIT0 = WIDTH'(2),
   parameter logic [WIDTH-1:0] INIT_REST = '0,
   localparam int TS = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int OW = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CE,
   input  logic             FLUSH,
   input  logic [WIDTH-1:0] I,
   input  logic             I_VALID,
   input  logic [TS-1:0]    TAP_SEL,
   output logic [WIDTH-1:0] O,
   output logic             O_VALID,
   output logic [WIDTH-1:0] TAP_O,
   output logic             TAP_VALID,
   output logic [OW-1:0]    OCC
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [OW-1:0]    occ_q;

   // I_VALID qualifies I; a word enters stage 0 only on an edge with CE=1 and FLUSH=0,
   // and leaves the chain when stage DEPTH-1 is overwritten on such an edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_q[k] <= (k == 0) ? INIT0 : INIT_REST;
         end
         valid_q <= '0;
         occ_q   <= '0;
      end else if (FLUSH) begin
         valid_q <= '0;
         occ_q   <= '0;
      end else if (CE) begin
         stage_q[0] <= I;
         valid_q[0] <= I_VALID;
         for (int k = 1; k < DEPTH; k++) begin
            stage_q[k] <= stage_q[k-1];
            valid_q[k] <= valid_q[k-1];
         end
         occ_q <= occ_q + OW'(I_VALID) - OW'(valid_q[DEPTH-1]);
      end
   end

   assign O       = stage_q[DEPTH-1];
   assign O_VALID = valid_q[DEPTH-1];
   assign OCC     = occ_q;

`ifdef DELAY_LINE_PR_TAP_EN
   // Out-of-range selections fall through to the zero defaults.
   always_comb begin
      TAP_O     = '0;
      TAP_VALID = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (TAP_SEL == TS'(k)) begin
            TAP_O     = stage_q[k];
            TAP_VALID = valid_q[k];
         end
      end
   end
`else
   logic unused_tap_sel;
   assign unused_tap_sel = ^TAP_SEL;
   assign TAP_O          = O;
   assign TAP_VALID      = O_VALID;
`endif

endmodule
